// File: rtl/chiplet_types_pkg.sv
// Shared types for the chiplet endpoint blocks.
//   word_t       : 32-bit bus address / data word
//   strobe_t     : per-byte write strobes for one word
//   arb_state_t  : cache arbiter grant state (IDLE, OWNED)
//   bus_req_t    : one requester's bus beat (ren, wen, addr, wdata, strobe)
package chiplet_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  strobe_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic    ren;
        logic    wen;
        word_t   addr;
        word_t   wdata;
        strobe_t strobe;
    } bus_req_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set bit of mask, searching from ptr
// upward and wrapping modulo NUM_REQ. Purely combinational.
//   ptr   in  IDX_W    highest-priority index
//   mask  in  NUM_REQ  candidate requesters
//   valid out 1        mask has at least one bit set
//   idx   out IDX_W    chosen index (0 when !valid)
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [IDX_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] pos;

    // Walk the offsets from farthest to nearest so the nearest hit to ptr
    // is the last assignment and wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (mask[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing the single-ported word cache between NUM_REQ
// bus requesters. A grant is held across consecutive beats of one requester
// and handed off with no idle bubble after MAX_BURST beats when another
// requester is waiting.
//   clk, n_rst               clock, async active-low reset
//   req_ren/req_wen          per-requester read / write enables
//   req_addr/wdata/strobe    per-requester beat payload
//   req_stall                per-requester stall (1 = beat not accepted)
//   req_rdata                shared read data (= mem_rdata)
//   mem_*                    cache peripheral bus, mem_stall from the cache
//   owner_valid/owner_idx    current grant (idx 0 when no grant)
module cache_arbiter
    import chiplet_types_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 4,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NUM_REQ-1:0]       req_ren,
    input  logic [NUM_REQ-1:0]       req_wen,
    input  logic [NUM_REQ-1:0][31:0] req_addr,
    input  logic [NUM_REQ-1:0][31:0] req_wdata,
    input  logic [NUM_REQ-1:0][3:0]  req_strobe,
    output logic [NUM_REQ-1:0]       req_stall,
    output logic [31:0]              req_rdata,
    output logic                     mem_ren,
    output logic                     mem_wen,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_strobe,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_stall,
    output logic                     owner_valid,
    output logic [IDX_W-1:0]         owner_idx
);

    localparam int             BCW       = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

    arb_state_t                state, state_nx;
    logic [IDX_W-1:0]          owner, owner_nx;
    logic [IDX_W-1:0]          rr_ptr, rr_ptr_nx;
    logic [BCW-1:0]            beat_cnt, beat_nx;

    bus_req_t [NUM_REQ-1:0]    req_bus;
    bus_req_t                  sel;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        others;
    logic [IDX_W-1:0]          owner_inc;
    logic                      beat_done;
    logic                      release_grant;
    logic                      acq_vld, ho_vld;
    logic [IDX_W-1:0]          acq_idx, ho_idx;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign req[i]     = req_ren[i] | req_wen[i];
        assign req_bus[i] = '{ren:    req_ren[i],
                               wen:    req_wen[i],
                               addr:   req_addr[i],
                               wdata:  req_wdata[i],
                               strobe: req_strobe[i]};
    end

    assign sel       = req_bus[owner];
    assign owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

    always_comb begin
        others        = req;
        others[owner] = 1'b0;
    end

    assign beat_done = (state == OWNED) && req[owner] && !mem_stall;

    // Release when the owner goes quiet, or when its burst budget is spent
    // and somebody else is waiting. A stalled beat never releases.
    assign release_grant = (state == OWNED) &&
                           (!req[owner] || (beat_done && beat_cnt == LAST_BEAT && ho_vld));

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick_acq (
        .ptr   (rr_ptr),
        .mask  (req),
        .valid (acq_vld),
        .idx   (acq_idx)
    );

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick_ho (
        .ptr   (owner_inc),
        .mask  (others),
        .valid (ho_vld),
        .idx   (ho_idx)
    );

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_ptr_nx;
            beat_cnt <= beat_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        rr_ptr_nx = rr_ptr;
        beat_nx   = beat_cnt;
        unique case (state)
            IDLE: begin
                if (acq_vld) begin
                    state_nx = OWNED;
                    owner_nx = acq_idx;
                    beat_nx  = '0;
                end
            end
            OWNED: begin
                if (release_grant) begin
                    rr_ptr_nx = owner_inc;
                    beat_nx   = '0;
                    if (ho_vld) begin
                        owner_nx = ho_idx;    // direct handoff, no IDLE bubble
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (beat_done) begin
                    // Uncontended streams wrap the counter and keep the grant.
                    beat_nx = (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BCW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_strobe  = '0;
        req_stall   = req;
        owner_valid = 1'b0;
        owner_idx   = '0;
        if (state == OWNED) begin
            mem_ren          = sel.ren;
            mem_wen          = sel.wen;
            mem_addr         = sel.addr;
            mem_wdata        = sel.wdata;
            mem_strobe       = sel.strobe;
            req_stall[owner] = mem_stall;
            owner_valid      = 1'b1;
            owner_idx        = owner;
        end
    end

    assign req_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

    localparam int N  = 2;
    localparam int MB = 4;
    localparam int IW = $clog2(N);

    logic                clk = 1'b0;
    logic                n_rst;
    logic [N-1:0]        req_ren, req_wen, req_stall;
    logic [N-1:0][31:0]  req_addr, req_wdata;
    logic [N-1:0][3:0]   req_strobe;
    logic [31:0]         req_rdata;
    logic                mem_ren, mem_wen, mem_stall;
    logic [31:0]         mem_addr, mem_wdata, mem_rdata;
    logic [3:0]          mem_strobe;
    logic                owner_valid;
    logic [IW-1:0]       owner_idx;

    cache_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strobe(req_strobe), .req_stall(req_stall),
        .req_rdata(req_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_strobe(mem_strobe), .mem_rdata(mem_rdata),
        .mem_stall(mem_stall),
        .owner_valid(owner_valid), .owner_idx(owner_idx)
    );

    always #5 clk = ~clk;

    // 128-word cache behind the arbiter: same-cycle read, write on accepted beat
    logic [31:0] cache [128];
    assign mem_rdata = cache[mem_addr[8:2]];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 128; i++) cache[i] <= '0;
        end else if (mem_wen && !mem_stall) begin
            for (int b = 0; b < 4; b++)
                if (mem_strobe[b]) cache[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who holds the grant, where the rotation starts, and
    // how many beats the current holder has completed.
    int           m_owner;
    int           m_ptr;
    int           m_beats;
    logic [31:0]  ref_mem [128];
    logic [N-1:0] last_stall;

    function automatic int pick(input int ptr, input logic [N-1:0] m);
        for (int k = 0; k < N; k++)
            if (m[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic m_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    endtask

    task automatic m_check();
        logic [N-1:0] r;
        int o;
        r = req_ren | req_wen;
        o = m_owner;
        chk("owner_valid", 32'(owner_valid), 32'(o >= 0));
        chk("owner_idx", 32'(owner_idx), (o >= 0) ? 32'(o) : 32'd0);
        for (int i = 0; i < N; i++)
            chk("req_stall", 32'(req_stall[i]), (i == o) ? 32'(mem_stall) : 32'(r[i]));
        if (o >= 0) begin
            chk("mem_ren", 32'(mem_ren), 32'(req_ren[o]));
            chk("mem_wen", 32'(mem_wen), 32'(req_wen[o]));
            chk("mem_addr", mem_addr, req_addr[o]);
            chk("mem_wdata", mem_wdata, req_wdata[o]);
            chk("mem_strobe", 32'(mem_strobe), 32'(req_strobe[o]));
            if (req_ren[o] && !mem_stall)
                chk("rdata", req_rdata, ref_mem[req_addr[o][8:2]]);
        end else begin
            chk("idle_bus", {mem_ren, mem_wen, mem_strobe} == 6'd0 &&
                            mem_addr == 32'd0 && mem_wdata == 32'd0 ? 32'd1 : 32'd0, 32'd1);
        end
        chk("rdata_pass", req_rdata, mem_rdata);
    endtask

    task automatic m_update();
        logic [N-1:0] r, oth;
        int  o;
        bit  done, rel;
        r = req_ren | req_wen;
        if (m_owner < 0) begin
            if (r != '0) begin
                m_owner = pick(m_ptr, r);
                m_beats = 0;
            end
        end else begin
            o      = m_owner;
            oth    = r;
            oth[o] = 1'b0;
            done   = r[o] && !mem_stall;
            if (done) begin
                if (req_wen[o])
                    for (int b = 0; b < 4; b++)
                        if (req_strobe[o][b]) ref_mem[req_addr[o][8:2]][8*b +: 8] = req_wdata[o][8*b +: 8];
                m_beats++;
            end
            rel = !r[o] || (done && (m_beats % MB) == 0 && oth != '0);
            if (rel) begin
                m_ptr = (o + 1) % N;
                if (oth != '0) begin
                    m_owner = pick((o + 1) % N, oth);
                    m_beats = 0;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic tick_chk();
        @(negedge clk);
        m_check();
        last_stall = req_stall;
    endtask

    task automatic tick_end();
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        req_ren = '0; req_wen = '0; req_addr = '0; req_wdata = '0; req_strobe = '0;
        mem_stall = 1'b0;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        m_reset();
        #1;
        m_check();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        clr_inputs();
        n_rst = 1'b0;
        m_reset();
        last_stall = '0;
        #2;
        // reset state, with a request visible during reset
        req_ren[1] = 1'b1;
        #1;
        chk("rst_owner_valid", 32'(owner_valid), 32'd0);
        chk("rst_owner_idx", 32'(owner_idx), 32'd0);
        chk("rst_mem_ren", 32'(mem_ren), 32'd1 - 32'd1);
        chk("rst_stall_eq_req", 32'(req_stall), 32'h2);
        req_ren[1] = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // single write then read
        req_wen[0] = 1'b1; req_addr[0] = 32'h10; req_wdata[0] = 32'hDEADBEEF; req_strobe[0] = 4'hF;
        tick_chk(); chk("s1_acq_stall", 32'(req_stall[0]), 32'd1); tick_end();
        tick_chk(); chk("s1_mem_wen", 32'(mem_wen), 32'd1); tick_end();
        req_wen[0] = 1'b0; req_ren[0] = 1'b1;
        tick_chk();
        chk("s1_rdata", req_rdata, 32'hDEADBEEF);
        chk("s1_rd_nostall", 32'(req_stall[0]), 32'd0);
        tick_end();
        req_ren[0] = 1'b0;
        tick_chk(); tick_end();

        // contention from reset: 4 beats each, no bubble at handoff
        do_reset();
        req_wen = '1; req_strobe = '1;
        req_addr[0] = 32'h20; req_wdata[0] = 32'h1111_0000;
        req_addr[1] = 32'h24; req_wdata[1] = 32'h2222_0000;
        for (int c = 0; c < 10; c++) begin
            tick_chk();
            chk("s2_valid", 32'(owner_valid), (c == 0) ? 32'd0 : 32'd1);
            chk("s2_owner", 32'(owner_idx), (c >= 5 && c <= 8) ? 32'd1 : 32'd0);
            tick_end();
        end

        // reset mid-burst: grant dropped at once, req0 wins afterwards
        do_reset();
        for (int c = 0; c < 2; c++) begin
            tick_chk(); tick_end();
        end
        #2;
        n_rst = 1'b0;
        #1;
        chk("s6_mem_wen", 32'(mem_wen), 32'd0);
        chk("s6_valid", 32'(owner_valid), 32'd0);
        m_reset();
        @(negedge clk);
        m_check();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        tick_chk(); chk("s6_idle", 32'(owner_valid), 32'd0); tick_end();
        tick_chk();
        chk("s6_win_valid", 32'(owner_valid), 32'd1);
        chk("s6_win_idx", 32'(owner_idx), 32'd0);
        tick_end();

        // randomized traffic with downstream stalls
        clr_inputs();
        tick_chk(); tick_end();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ((req_ren[i] | req_wen[i]) && last_stall[i]) begin
                    if ($urandom_range(0, 15) == 0) begin
                        req_ren[i] = 1'b0;
                        req_wen[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) != 0) begin
                    req_wen[i]    = ($urandom_range(0, 1) == 1);
                    req_ren[i]    = !req_wen[i];
                    req_addr[i]   = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    req_wdata[i]  = $urandom;
                    req_strobe[i] = 4'($urandom);
                end else begin
                    req_ren[i] = 1'b0;
                    req_wen[i] = 1'b0;
                end
            end
            mem_stall = ($urandom_range(0, 3) == 0);
            tick_chk();
            tick_end();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Round-robin arbiter that shares the endpoint's single-ported word cache between `NUM_REQ` bus requesters, e.g. the packet RX writer, TX reader and host port. It sits between the requesters and the cache's peripheral bus. It holds a grant across consecutive beats of one requester, bounded by a burst limit, so a streaming requester keeps zero-bubble throughput without starving others. Downstream rdata is returned in the same cycle the beat completes.

## Interface

Parameters:
- `NUM_REQ`, 2: number of requesters; must be ≥ 2.
- `MAX_BURST`, 4: maximum beats per grant while another requester is pending; must be ≥ 1.
- `IDX_W`, `$clog2(NUM_REQ)`: derived; width of the owner index.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `n_rst`  in  1  asynchronous, active-low reset.
- `req_ren`  in  NUM_REQ  per-requester read enable.
- `req_wen`  in  NUM_REQ  per-requester write enable.
- `req_addr`  in  NUM_REQ×32  per-requester byte address.
- `req_wdata`  in  NUM_REQ×32  per-requester write data.
- `req_strobe`  in  NUM_REQ×4  per-requester byte strobes.
- `req_stall`  out  NUM_REQ  stall to each requester; 1 means the beat is not accepted this cycle.
- `req_rdata`  out  32  shared read data, equal to `mem_rdata`; valid only for the owner on a completing read.
- `mem_ren`, `mem_wen`  out  1 each  to cache.
- `mem_addr`, `mem_wdata`  out  32 each  to cache.
- `mem_strobe`  out  4  to cache.
- `mem_rdata`  in  32  from cache.
- `mem_stall`  in  1  from cache (`request_stall`).
- `owner_valid`  out  1  a grant is held.
- `owner_idx`  out  IDX_W  current owner; 0 when there is no grant.

## Operation

State and registers:
- `state` ∈ {IDLE, OWNED}
- `owner` (IDX_W bits)
- `rr_ptr` (IDX_W bits): highest-priority index for the next pick.
- `beat_cnt` (`$clog2(MAX_BURST+1)` bits)

Definitions:
- `req[i]` = `req_ren[i] | req_wen[i]`.
- A beat completes when `state==OWNED`, `req[owner]` = 1 and `mem_stall` = 0.
- `pick(ptr, mask)`: the first set bit of `mask` searching `ptr, ptr+1, …`, wrapping modulo NUM_REQ.

IDLE:
- All `mem_*` outputs are 0 and `req_stall[i]` = `req[i]`.
- At the clock edge, if any `req` is set: `owner` ← `pick(rr_ptr, req)`, state ← OWNED, `beat_cnt` ← 0.

OWNED:
- The `mem_*` outputs mirror the owner's request.
- `req_stall[owner]` = `mem_stall`; for every other requester, `req_stall[i]` = `req[i]`.
- `others` = `req` with the owner's bit cleared.
- Release at the clock edge when either:
  - (a) `req[owner]` = 0, or
  - (b) a beat completes, `beat_cnt` = MAX_BURST−1, and `others` ≠ 0.
- On release:
  - `rr_ptr` ← `owner`+1 (mod NUM_REQ).
  - If `others` ≠ 0, the next owner is `pick(owner+1, others)`: state stays OWNED and `beat_cnt` ← 0. There is no IDLE bubble.
  - Otherwise state ← IDLE.
- No release and a beat completes: `beat_cnt` increments. When it reaches MAX_BURST−1 with no contention, it wraps to 0 instead.
- The owner is never changed while `req[owner]` = 1 and `mem_stall` = 1; the in-flight beat always finishes.

Other rules:
- If a requester asserts ren and wen together, both are forwarded unchanged; avoiding this is the requester's responsibility.
- Requesters must hold addr, wdata and strobe stable while stalled.

## Timing

- Reset (asynchronous, takes effect immediately): state = IDLE, `owner` = 0, `rr_ptr` = 0, `beat_cnt` = 0. Consequently all `mem_*` = 0, `owner_valid` = 0, `owner_idx` = 0, and `req_stall` = `req`.
- Reset mid-burst drops the grant immediately. The interrupted beat is not completed.
- Acquire latency from IDLE: 1 stall cycle. The beat is forwarded in the following cycle.
- Handoff latency between owners: 0 bubble cycles.
- `req_stall`, `mem_*` and `req_rdata` are combinational from the registered state and the current inputs. There is no combinational path from `mem_rdata` to any stall.
- Throughput: 1 beat per cycle for the owner when `mem_stall` = 0.

## Structure

- `chiplet_types_pkg`: add `arb_state_t` (IDLE, OWNED). Reuse `word_t` for addr and data.
- Sub-module `rr_pick`: purely combinational; parameter NUM_REQ; inputs `ptr` and `mask`; outputs `valid` and `idx`. It is used for both the acquire pick and the handoff pick.

## Test plan

Setup: a cache of 128 words behind the arbiter, NUM_REQ=2, MAX_BURST=4.

1. **Single write/read.** Req0 writes 0xDEADBEEF to 0x10 with strobe 0xF at cycle 0. Required: `req_stall[0]`=1 at cycle 0, `mem_wen`=1 at cycle 1. Req0 then reads 0x10; required: `req_rdata`=0xDEADBEEF with no extra stall.
2. **Contention from reset.** Both requesters issue continuous writes from cycle 0. Required: req0 completes 4 beats (cycles 1–4), req1 owns at cycle 5 with no bubble and completes 4 beats, then req0 owns again.
3. **Owner drops.** Req1 owns; req1 deasserts while req0 is pending. Required: `owner_idx`=0 on the next cycle and `rr_ptr`=0.
4. **Downstream stall.** `mem_stall` is held for 3 cycles on the beat at `beat_cnt`=3 while req1 is pending. Required: req0 keeps ownership and `beat_cnt` stays 3; handoff occurs on the edge after the stall clears.
5. **Uncontended stream.** Req1 alone issues 10 back-to-back reads. Required: one initial stall cycle, then 10 consecutive completions with `owner_idx`=1 throughout.
6. **Reset mid-burst.** Drop `n_rst` at cycle 2 of scenario 2. Required: `mem_wen`=0 and `owner_valid`=0 immediately. After release, req0 wins first.
